// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the HI/LO multiply/divide unit.
// Holds the op code values, the FSM state type, the accumulate-mode type
// and small predicates used by the top level to classify an op.
package mdu_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    // How the finished product is folded into {hi,lo}.
    typedef enum logic [1:0] {
        ACC_SET = 2'd0,
        ACC_ADD = 2'd1,
        ACC_SUB = 2'd2
    } acc_mode_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul_op = 1'b1;
            default:                                                 is_mul_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        case (op)
            OP_DIV, OP_DIVU: is_div_op = 1'b1;
            default:         is_div_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        case (op)
            OP_MULT, OP_DIV, OP_MADD, OP_MSUB: is_signed_op = 1'b1;
            default:                           is_signed_op = 1'b0;
        endcase
    endfunction

    function automatic acc_mode_e acc_mode(input logic [3:0] op);
        case (op)
            OP_MADD, OP_MADDU: acc_mode = ACC_ADD;
            OP_MSUB, OP_MSUBU: acc_mode = ACC_SUB;
            default:           acc_mode = ACC_SET;
        endcase
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: iterative restoring divider.
// start_i loads |a|,|b| and sign info; WIDTH iterations follow, then one
// cycle where valid_o is high and the sign-corrected result is presented.
// The consumer captures quo_o/rem_o on that edge. cancel_i aborts.
// Divide-by-zero gives quo=all ones, rem=a; signed MIN/-1 gives quo=MIN, rem=0.
// Ports: clk, rst_n, start_i, cancel_i, signed_i, a_i (dividend), b_i (divisor),
//        valid_o, quo_o, rem_o.
module mdu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             cancel_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH);

    logic             run_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, div_q, dvd_q;
    logic             qneg_q, rneg_q, dz_q, ovf_q;

    logic [WIDTH-1:0] a_abs_s, b_abs_s, rem_nxt_s, quo_nxt_s;
    logic [WIDTH:0]   shift_s, trial_s;

    // Operand magnitudes; |MIN| still fits as an unsigned WIDTH-bit value.
    always_comb begin
        a_abs_s = a_i;
        b_abs_s = b_i;
        if (signed_i && a_i[WIDTH-1]) begin
            a_abs_s = -a_i;
        end else begin
            a_abs_s = a_i;
        end
        if (signed_i && b_i[WIDTH-1]) begin
            b_abs_s = -b_i;
        end else begin
            b_abs_s = b_i;
        end
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shift_s   = {rem_q, quo_q[WIDTH-1]};
        trial_s   = shift_s - {1'b0, div_q};
        rem_nxt_s = shift_s[WIDTH-1:0];
        quo_nxt_s = {quo_q[WIDTH-2:0], 1'b0};
        if (!trial_s[WIDTH]) begin
            rem_nxt_s = trial_s[WIDTH-1:0];
            quo_nxt_s = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt_s = shift_s[WIDTH-1:0];
            quo_nxt_s = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Result presentation with special cases and sign correction.
    always_comb begin
        valid_o = run_q && (cnt_q == LAST);
        quo_o   = quo_q;
        rem_o   = rem_q;
        if (dz_q) begin
            quo_o = {WIDTH{1'b1}};
            rem_o = dvd_q;
        end else if (ovf_q) begin
            quo_o = {1'b1, {(WIDTH-1){1'b0}}};
            rem_o = {WIDTH{1'b0}};
        end else begin
            quo_o = qneg_q ? -quo_q : quo_q;
            rem_o = rneg_q ? -rem_q : rem_q;
        end
    end

    // Divider state: load on start, iterate, release after the result cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            dvd_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (cancel_i) begin
            run_q <= 1'b0;
        end else if (start_i) begin
            run_q  <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= a_abs_s;
            div_q  <= b_abs_s;
            dvd_q  <= a_i;
            qneg_q <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            rneg_q <= signed_i && a_i[WIDTH-1];
            dz_q   <= (b_i == {WIDTH{1'b0}});
            ovf_q  <= signed_i && (a_i == {1'b1, {(WIDTH-1){1'b0}}})
                               && (b_i == {WIDTH{1'b1}});
        end else if (run_q) begin
            if (cnt_q != LAST) begin
                rem_q <= rem_nxt_s;
                quo_q <= quo_nxt_s;
                cnt_q <= cnt_q + CW'(1);
            end else begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: multiply/divide unit owning the HI/LO registers.
// Multiply-class ops commit MUL_LATENCY edges after accept through a product
// register chain; divides use mdu_divider and commit WIDTH+1 edges after accept.
// MTHI/MTLO write at the accept edge. cancel aborts an in-flight op.
// Ports: clk, rst_n, start, op, a, b, cancel (inputs);
//        busy, done, hi, lo (registered outputs).
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                CNT_W    = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MUL_LATENCY - 1);

    mdu_state_e       state_q, state_d;
    acc_mode_e        mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] prod_q [MUL_LATENCY];

    logic               accept_s, mul_go_s, div_go_s;
    logic [2*WIDTH-1:0] a_ext_s, b_ext_s, prod_s, mul_res_s;
    logic               div_valid_s;
    logic [WIDTH-1:0]   div_quo_s, div_rem_s;

    assign accept_s = start && (state_q == ST_IDLE) && !cancel;
    assign mul_go_s = accept_s && is_mul_op(op);
    assign div_go_s = accept_s && is_div_op(op);

    // Extend operands to 2*WIDTH so one unsigned multiply serves both signednesses.
    always_comb begin
        a_ext_s = {{WIDTH{1'b0}}, a};
        b_ext_s = {{WIDTH{1'b0}}, b};
        if (is_signed_op(op)) begin
            a_ext_s = {{WIDTH{a[WIDTH-1]}}, a};
            b_ext_s = {{WIDTH{b[WIDTH-1]}}, b};
        end else begin
            a_ext_s = {{WIDTH{1'b0}}, a};
            b_ext_s = {{WIDTH{1'b0}}, b};
        end
        prod_s = a_ext_s * b_ext_s;
    end

    // Product chain: stage 0 captures at accept, later stages follow one per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LATENCY; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            if (mul_go_s) begin
                prod_q[0] <= prod_s;
            end
            for (int i = 1; i < MUL_LATENCY; i++) begin
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    // Fold the final product stage into the current {hi,lo}.
    always_comb begin
        case (mode_q)
            ACC_ADD: mul_res_s = {hi_q, lo_q} + prod_q[MUL_LATENCY-1];
            ACC_SUB: mul_res_s = {hi_q, lo_q} - prod_q[MUL_LATENCY-1];
            default: mul_res_s = prod_q[MUL_LATENCY-1];
        endcase
    end

    mdu_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (div_go_s),
        .cancel_i (cancel),
        .signed_i (is_signed_op(op)),
        .a_i      (a),
        .b_i      (b),
        .valid_o  (div_valid_s),
        .quo_o    (div_quo_s),
        .rem_o    (div_rem_s)
    );

    // Next-state and HI/LO update; cancel is checked before commit so it wins.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_mul_op(op)) begin
                        state_d = ST_MUL;
                        cnt_d   = '0;
                        mode_d  = acc_mode(op);
                    end else if (is_div_op(op)) begin
                        state_d = ST_DIV;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    {hi_d, lo_d} = mul_res_s;
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DIV: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (div_valid_s) begin
                    hi_d    = div_rem_s;
                    lo_d    = div_quo_s;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DIV;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Control and architectural registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= ACC_SET;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: directed vectors plus random ops. Expected {hi,lo}
// and completion cycle are queued at issue; a negedge monitor pops and
// compares whenever done is seen.
module tb_mdu_hilo;

    localparam int W = 32;
    localparam logic [3:0] T_MULT = 4'd1, T_MULTU = 4'd2, T_DIV = 4'd3, T_DIVU = 4'd4;
    localparam logic [3:0] T_MADD = 4'd5, T_MADDU = 4'd6, T_MSUB = 4'd7, T_MSUBU = 4'd8;
    localparam logic [3:0] T_MTHI = 4'd9, T_MTLO = 4'd10;

    logic         clk, rst_n, start, cancel;
    logic [3:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         busy, done;

    typedef struct {
        logic [63:0] hilo;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [63:0] m_hilo = 64'd0;

    mdu_hilo #(.WIDTH(W), .MUL_LATENCY(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference behaviour written from the arithmetic rules.
    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [63:0] acc);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == T_MULT || o == T_MADD || o == T_MSUB) p = sx * sy;
        else p = {32'd0, x} * {32'd0, y};
        case (o)
            T_MULT, T_MULTU: return p;
            T_MADD, T_MADDU: return acc + p;
            T_MSUB, T_MSUBU: return acc - p;
            T_DIV: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            T_DIVU: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
            default: return acc;
        endcase
    endfunction

    function automatic int latency(input logic [3:0] o);
        if (o >= T_MULT && o <= T_MSUBU && o != T_DIV && o != T_DIVU) return 3;
        if (o == T_DIV || o == T_DIVU) return W + 1;
        return 0;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("hilo", {hi, lo}, e.hilo);
                check("done_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit expect_done);
        logic [63:0] res;
        int          lat;
        exp_t        e;
        wait_idle();
        res = model(o, x, y, m_hilo);
        lat = latency(o);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        if (lat > 0) begin
            check("busy_after_accept", {63'd0, busy}, 64'd1);
            if (expect_done) begin
                e.hilo = res;
                e.due  = cyc + lat;
                sb.push_back(e);
                m_hilo = res;
            end
        end else begin
            if (o == T_MTHI) m_hilo[63:32] = x;
            if (o == T_MTLO) m_hilo[31:0] = x;
            check("idle_op_busy", {63'd0, busy}, 64'd0);
            check("idle_op_hilo", {hi, lo}, m_hilo);
        end
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = 4'd0; a = '0; b = '0;
        @(negedge clk);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test vectors with literal expectations.
        issue(T_MULT, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b1);
        wait_idle();
        check("t1", {hi, lo}, 64'h00000000_00000004);
        issue(T_MTHI, 32'hFFFFFFFE, 32'd0, 1'b1);
        issue(T_MTLO, 32'hFFFFFFFE, 32'd0, 1'b1);
        issue(T_MSUB, 32'd3, 32'hFFFFFFFE, 1'b1);
        wait_idle();
        check("t2_msub", {hi, lo}, 64'hFFFFFFFF_00000004);
        issue(T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_idle();
        check("t2_multu", {hi, lo}, 64'hFFFFFFFE_00000001);
        issue(T_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
        wait_idle();
        check("t3_div", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        issue(T_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_idle();
        check("t3_ovf", {hi, lo}, 64'h00000000_80000000);
        issue(T_DIVU, 32'h1234, 32'd0, 1'b1);
        wait_idle();
        check("t4_dz", {hi, lo}, 64'h00001234_FFFFFFFF);

        // Cancel a divide, with an ignored start while busy.
        issue(T_DIV, 32'd1000, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1; op = T_MTHI; a = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_while_busy_hilo", {hi, lo}, m_hilo);
        check("start_while_busy_busy", {63'd0, busy}, 64'd1);
        repeat (5) @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel_busy", {63'd0, busy}, 64'd0);
        check("cancel_hilo", {hi, lo}, m_hilo);
        repeat (40) @(negedge clk);
        check("cancel_hilo_late", {hi, lo}, m_hilo);

        // start together with cancel while idle is not accepted.
        start = 1'b1; cancel = 1'b1; op = T_MTLO; a = 32'h0000ABCD;
        @(posedge clk);
        #1;
        op = T_DIV;
        @(posedge clk);
        #1;
        start = 1'b0; cancel = 1'b0;
        check("start_cancel_hilo", {hi, lo}, m_hilo);
        check("start_cancel_busy", {63'd0, busy}, 64'd0);

        // Reset in the middle of a MADD.
        issue(T_MADD, 32'd5, 32'd6, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_hilo", {hi, lo}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        sb.delete();
        m_hilo = 64'd0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(T_MTLO, 32'd5, 32'd0, 1'b1);
        check("post_rst_lo", {32'd0, lo}, 64'd5);

        // Random traffic, issued back-to-back as soon as busy drops.
        for (int i = 0; i < 150; i++) begin
            issue(4'($urandom_range(0, 15)), rand_val(), rand_val(), 1'b1);
        end
        wait_idle();
        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("final_hilo", {hi, lo}, m_hilo);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
